// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a 2-entry skid buffer: registered in_ready, redirect flush,
// occupancy report and a saturating stall counter.
module if_id_skid #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_INST = {DATA_W{1'b0}},
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_inst,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_r, state_nxt_s;
   logic              push_s, pop_s;
   logic [ADDR_W-1:0] main_pc_r, main_pc_nxt_s, skid_pc_r, skid_pc_nxt_s;
   logic [DATA_W-1:0] main_inst_r, main_inst_nxt_s, skid_inst_r, skid_inst_nxt_s;
   logic              out_valid_r, out_valid_nxt_s, in_ready_r, in_ready_nxt_s;
   logic [1:0]        occupancy_r, occupancy_nxt_s;
   logic [CNT_W-1:0]  stall_cnt_r;

   assign push_s = in_valid && in_ready_r;
   assign pop_s  = out_valid_r && out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush wins over both handshakes
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (push_s) state_nxt_s = ONE;
               else        state_nxt_s = EMPTY;
            end
            ONE: begin
               if (push_s && !pop_s)      state_nxt_s = FULL;
               else if (!push_s && pop_s) state_nxt_s = EMPTY;
               else                       state_nxt_s = ONE;
            end
            FULL: begin
               if (pop_s) state_nxt_s = ONE;
               else       state_nxt_s = FULL;
            end
            default: state_nxt_s = EMPTY;
         endcase
      end
   end

   // Output/datapath logic; an emptied main slot is loaded with bubble values so out_* need no mux
   always_comb begin
      main_pc_nxt_s   = main_pc_r;
      main_inst_nxt_s = main_inst_r;
      skid_pc_nxt_s   = skid_pc_r;
      skid_inst_nxt_s = skid_inst_r;
      if (flush) begin
         main_pc_nxt_s   = PC_ZERO;
         main_inst_nxt_s = NOP_INST;
         skid_pc_nxt_s   = PC_ZERO;
         skid_inst_nxt_s = NOP_INST;
      end else begin
         case (state_r)
            EMPTY: begin
               if (push_s) begin
                  main_pc_nxt_s   = in_pc;
                  main_inst_nxt_s = in_inst;
               end else begin
                  main_pc_nxt_s   = main_pc_r;
                  main_inst_nxt_s = main_inst_r;
               end
            end
            ONE: begin
               if (push_s && pop_s) begin
                  main_pc_nxt_s   = in_pc;
                  main_inst_nxt_s = in_inst;
               end else if (push_s) begin
                  skid_pc_nxt_s   = in_pc;
                  skid_inst_nxt_s = in_inst;
               end else if (pop_s) begin
                  main_pc_nxt_s   = PC_ZERO;
                  main_inst_nxt_s = NOP_INST;
               end else begin
                  main_pc_nxt_s   = main_pc_r;
                  main_inst_nxt_s = main_inst_r;
               end
            end
            FULL: begin
               if (pop_s) begin
                  main_pc_nxt_s   = skid_pc_r;
                  main_inst_nxt_s = skid_inst_r;
                  skid_pc_nxt_s   = PC_ZERO;
                  skid_inst_nxt_s = NOP_INST;
               end else begin
                  main_pc_nxt_s   = main_pc_r;
                  main_inst_nxt_s = main_inst_r;
               end
            end
            default: begin
               main_pc_nxt_s   = PC_ZERO;
               main_inst_nxt_s = NOP_INST;
               skid_pc_nxt_s   = PC_ZERO;
               skid_inst_nxt_s = NOP_INST;
            end
         endcase
      end

      out_valid_nxt_s = (state_nxt_s != EMPTY);
      in_ready_nxt_s  = (state_nxt_s != FULL);
      case (state_nxt_s)
         EMPTY:   occupancy_nxt_s = 2'd0;
         ONE:     occupancy_nxt_s = 2'd1;
         FULL:    occupancy_nxt_s = 2'd2;
         default: occupancy_nxt_s = 2'd0;
      endcase
   end

   // Payload and handshake flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         main_pc_r   <= PC_ZERO;
         main_inst_r <= NOP_INST;
         skid_pc_r   <= PC_ZERO;
         skid_inst_r <= NOP_INST;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         occupancy_r <= 2'd0;
      end else begin
         main_pc_r   <= main_pc_nxt_s;
         main_inst_r <= main_inst_nxt_s;
         skid_pc_r   <= skid_pc_nxt_s;
         skid_inst_r <= skid_inst_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         in_ready_r  <= in_ready_nxt_s;
         occupancy_r <= occupancy_nxt_s;
      end
   end

   // Saturating stall counter; survives flush, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_pc    = main_pc_r;
   assign out_inst  = main_inst_r;
   assign occupancy = occupancy_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a queue model with capacity 2 collects accepted pushes; a negedge
// monitor compares the DUT's outputs with the model head, occupancy and stall count.
module tb_if_id_skid;

   localparam int          CNT_W   = 4;
   localparam int          CNT_SAT = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP     = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [1:0]  occupancy;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];
   int   exp_stall = 0;
   bit   live = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   if_id_skid #(.ADDR_W(32), .DATA_W(32), .NOP_INST(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a FIFO of at most two entries, updated at every clock edge
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            exp_q.delete();
            exp_stall = 0;
         end else begin
            bit do_pop, do_push;
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = in_valid && (exp_q.size() < 2);
            if ((exp_q.size() > 0) && !out_ready && (exp_stall < CNT_SAT)) exp_stall++;
            if (flush) begin
               exp_q.delete();
            end else begin
               if (do_pop) void'(exp_q.pop_front());
               if (do_push) exp_q.push_back('{pc: in_pc, inst: in_inst});
            end
         end
         live = 1'b1;
      end
   end

   // Monitor: compare presented output against the model every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (exp_q.size() > 0) begin
               chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
               chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
            end else begin
               chk("bubble_pc", 64'(out_pc), 64'd0);
               chk("bubble_inst", 64'(out_inst), 64'(NOP));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = 32'h0; in_inst = 32'h0;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'(NOP));

      // single push, one-cycle latency
      rst = 1'b0; in_valid = 1'b1; in_pc = 32'h0000_0040; in_inst = 32'h2408_0005; out_ready = 1'b1;
      tick();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_pc", 64'(out_pc), 64'h40);
      chk("single_occ", 64'(occupancy), 64'd1);
      in_valid = 1'b0;
      tick();
      chk("single_drain_valid", 64'(out_valid), 64'd0);
      chk("single_drain_inst", 64'(out_inst), 64'(NOP));

      // back-to-back stream
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_pc = 32'(i * 4); in_inst = 32'hA000_0000 + 32'(i);
         tick();
         chk("stream_pc", 64'(out_pc), 64'(i * 4));
         chk("stream_in_ready", 64'(in_ready), 64'd1);
         chk("stream_stall", 64'(stall_cnt), 64'd0);
      end
      in_valid = 1'b0;
      tick();

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h10; in_inst = 32'h1111_0010;
      tick();
      chk("bp_occ1", 64'(occupancy), 64'd1);
      chk("bp_ready1", 64'(in_ready), 64'd1);
      in_pc = 32'h14; in_inst = 32'h1111_0014;
      tick();
      chk("bp_occ2", 64'(occupancy), 64'd2);
      chk("bp_ready0", 64'(in_ready), 64'd0);
      chk("bp_stall1", 64'(stall_cnt), 64'd1);
      in_pc = 32'h18; in_inst = 32'h1111_0018;
      tick();
      tick();
      chk("bp_stall3", 64'(stall_cnt), 64'd3);
      chk("bp_head", 64'(out_pc), 64'h10);
      out_ready = 1'b1;
      tick();
      chk("bp_pop1", 64'(out_pc), 64'h14);
      tick();
      chk("bp_pop2", 64'(out_pc), 64'h18);
      in_valid = 1'b0;
      tick();
      chk("bp_empty", 64'(occupancy), 64'd0);

      // flush while full, with a simultaneous input
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'hA0; in_inst = 32'h2222_00A0;
      tick();
      in_pc = 32'hA4; in_inst = 32'h2222_00A4;
      tick();
      chk("fl_full", 64'(occupancy), 64'd2);
      flush = 1'b1; in_pc = 32'h80; in_inst = 32'h2222_0080;
      tick();
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("fl_dropped", 64'(out_valid), 64'd0);

      // stall counter saturation
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'hC0; in_inst = 32'h3333_00C0;
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat_15", 64'(stall_cnt), 64'(CNT_SAT));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_after_flush", 64'(stall_cnt), 64'(CNT_SAT));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sat_rst", 64'(stall_cnt), 64'd0);

      // randomised traffic against the model
      for (int c = 0; c < 10000; c++) begin
         rst       = ($urandom_range(0, 511) == 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_pc     = $urandom;
         in_inst   = $urandom;
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Carries PC plus instruction (or any instruction-side payload) between fetch and decode over a valid/ready handshake.
- A 2-entry skid buffer keeps `in_ready` registered, so the input side has no combinational path from `out_ready`.
- Adds synchronous flush for branch/exception redirect, an occupancy indicator and a saturating stall counter.

Parameters:
- ADDR_W, 32, width of `in_pc` / `out_pc`
- DATA_W, 32, width of `in_inst` / `out_inst`
- NOP_INST, 32'h0000_0000 (DATA_W bits), instruction value driven on `out_inst` when no entry is valid
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all held entries (redirect)
- in_valid  in  1  upstream payload valid
- in_ready  out  1  block can accept; registered
- in_pc  in  ADDR_W  fetch PC
- in_inst  in  DATA_W  fetched instruction
- out_valid  out  1  payload valid to decode
- out_ready  in  1  decode accepts
- out_pc  out  ADDR_W  PC to decode
- out_inst  out  DATA_W  instruction to decode
- occupancy  out  2  entries held (0, 1 or 2)
- stall_cnt  out  CNT_W  cycles with `out_valid` && !`out_ready`, saturating

Behaviour:
- Clock and reset: all state updates on posedge `clk`. `rst` is synchronous, active-high.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0
  - `out_pc`=0, `out_inst`=NOP_INST
  - skid entry cleared
- Storage: a main register drives the outputs; a skid register holds one extra entry.
- States:
  - EMPTY (occ 0)
  - ONE (main valid)
  - FULL (main + skid valid)
- Handshake definitions:
  - push = `in_valid` && `in_ready`
  - pop = `out_valid` && `out_ready`
- `in_ready` = (state != FULL), registered.
- `out_valid` = (state != EMPTY).
- Transitions (no flush):
  - EMPTY, push -> ONE; main <= input.
  - ONE, push && pop -> ONE; main <= input.
  - ONE, push && !pop -> FULL; skid <= input, main unchanged.
  - ONE, !push && pop -> EMPTY.
  - FULL, pop -> ONE; main <= skid. No push is possible because `in_ready`=0.
  - Any other case: hold state.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or reset.
- Latency: an entry pushed into EMPTY appears on the outputs the next cycle (1-cycle latency, same as the plain pipeline register). Full throughput is 1 entry/cycle when `out_ready` is held high.
- Invalid-output payload: whenever `out_valid`=0, `out_pc`=0 and `out_inst`=NOP_INST. Decode therefore sees a bubble as a NOP.
- flush:
  - Has priority over push and pop. Next cycle the block is in EMPTY: occupancy 0, `in_ready`=1, outputs at bubble values.
  - An input presented in the flush cycle is dropped, even if `in_ready`=1.
  - A pop in the flush cycle still completes on the consumer side; the block does not re-present that entry.
- `stall_cnt`:
  - Increments by 1 in each cycle where `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush; cleared only by `rst`.
- rst during operation: overrides flush and the handshakes. All entries are discarded and the block returns to its reset values on the next cycle.
- Payload regs, simultaneous events: in FULL with pop, main takes the skid contents while skid is invalidated in the same edge.

Test Plan:
- Reset then single push: `rst` 1 cycle; push pc=0x0000_0040, inst=0x2408_0005 with `out_ready`=1 -> the next cycle shows `out_valid`=1 and `out_pc`=0x40, `occupancy`=1; the cycle after shows `out_valid`=0 and `out_inst`=NOP_INST.
- Back-to-back stream: pcs 0x00, 0x04, … 0x3C pushed every cycle with `out_ready`=1 -> 16 pops in order, one per cycle after 1 cycle of latency; `in_ready` stays 1 and `stall_cnt` stays 0.
- Backpressure: `out_ready`=0, push 0x10, 0x14, 0x18 -> `occupancy` 1 then 2, `in_ready`=0 after the second push, 0x18 is held upstream; `stall_cnt` counts each stalled cycle; releasing `out_ready` pops 0x10, 0x14, 0x18 in order.
- Flush while FULL: with `occupancy`=2, assert `flush` together with `in_valid` (pc 0x80) -> the next cycle shows `occupancy`=0, `out_valid`=0, `in_ready`=1; 0x80 never appears on the outputs.
- Saturation: CNT_W=4, `out_valid`=1, `out_ready`=0 for 20 cycles -> `stall_cnt`=15; it stays at 15 through a flush; `rst` returns it to 0.
- Randomised push/pop/flush against a queue model for 10k cycles -> outputs match the model's order, no drops except flushed entries, `occupancy` matches the model every cycle.
